// File: rtl/uart_pkg.sv
// uart_pkg: shared types for the UART transmitter.
// Parity modes, FSM states and a frame-length helper.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  function automatic int unsigned frame_bits(
    input int unsigned dw,
    input logic        par_en,
    input logic        stop2
  );
    return 1 + dw + (par_en ? 1 : 0) + (stop2 ? 2 : 1);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with registered read data.
// The head word is valid in rdata_o whenever empty_o is low.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [DW-1:0]            wdata_i,
  input  logic                     pop_i,
  output logic [DW-1:0]            rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q, rptr_d;
  logic [AW:0]   level_q, level_d;
  logic [DW-1:0] rdata_q, rdata_d;

  assign rptr_d  = rptr_q + AW'(pop_i);
  assign level_d = level_q + (AW+1)'(push_i)
                 - (AW+1)'(pop_i);

  // Forward a word written into the slot that becomes the head.
  assign rdata_d = (push_i && wptr_q == rptr_d)
                 ? wdata_i : mem_q[rptr_d];

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      rdata_q <= '0;
    end else begin
      wptr_q  <= wptr_q + AW'(push_i);
      rptr_q  <= rptr_d;
      level_q <= level_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;
  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: AXI-Stream fed UART transmitter with FIFO.
// Divisor, parity and stop count are latched at frame start.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic [DIV_WIDTH-1:0]        cfg_baud_div,
  input  logic [1:0]                  cfg_parity,
  input  logic                        cfg_stop2,
  input  logic                        tx_enable,
  output logic                        tx,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int BW = $clog2(DATA_WIDTH);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [DIV_WIDTH-1:0]  baud_q, baud_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic                  par_en_q, par_en_d;
  logic                  parbit_q, parbit_d;
  logic                  stop2_q, stop2_d;
  logic                  tx_q, tx_d;
  logic                  rdy_q;

  logic                  fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  push, pop, can_start;
  logic                  tick, last_data, last_stop;

  uart_sync_fifo #(
    .DW    (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .wdata_i (s_axis_tdata),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign s_axis_tready = rdy_q & ~fifo_full;
  assign push      = s_axis_tvalid & s_axis_tready;
  assign can_start = tx_enable & ~fifo_empty;
  assign tick      = (baud_q == div_q - DIV_WIDTH'(1));
  assign last_data = (bit_q == BW'(DATA_WIDTH-1));
  assign last_stop = (bit_q == BW'(stop2_q));

  // Pop from IDLE or straight out of the final stop period.
  assign pop = can_start &
               ((state_q == ST_IDLE) |
                (state_q == ST_STOP & tick & last_stop));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      shreg_q  <= '0;
      div_q    <= DIV_WIDTH'(2);
      baud_q   <= '0;
      bit_q    <= '0;
      par_en_q <= 1'b0;
      parbit_q <= 1'b0;
      stop2_q  <= 1'b0;
      tx_q     <= 1'b1;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      div_q    <= div_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      par_en_q <= par_en_d;
      parbit_q <= parbit_d;
      stop2_q  <= stop2_d;
      tx_q     <= tx_d;
      rdy_q    <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (can_start) state_d = ST_START;
      ST_START:
        if (tick) state_d = ST_DATA;
      ST_DATA:
        if (tick && last_data)
          state_d = par_en_q ? ST_PARITY : ST_STOP;
      ST_PARITY:
        if (tick) state_d = ST_STOP;
      ST_STOP:
        if (tick && last_stop)
          state_d = can_start ? ST_START : ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    baud_d = (state_q == ST_IDLE || tick)
           ? '0 : baud_q + DIV_WIDTH'(1);

    bit_d = bit_q;
    if (tick && state_q == ST_DATA)
      bit_d = last_data ? '0 : bit_q + BW'(1);
    else if (tick && state_q == ST_STOP)
      bit_d = last_stop ? '0 : bit_q + BW'(1);

    shreg_d  = shreg_q;
    div_d    = div_q;
    par_en_d = par_en_q;
    parbit_d = parbit_q;
    stop2_d  = stop2_q;
    if (pop) begin
      shreg_d  = fifo_rdata;
      div_d    = (cfg_baud_div < DIV_WIDTH'(2))
               ? DIV_WIDTH'(2) : cfg_baud_div;
      stop2_d  = cfg_stop2;
      par_en_d = 1'b0;
      parbit_d = 1'b0;
      unique case (1'b1)
        cfg_parity == PAR_ODD: begin
          par_en_d = 1'b1;
          parbit_d = ~^fifo_rdata;
        end
        cfg_parity == PAR_EVEN: begin
          par_en_d = 1'b1;
          parbit_d = ^fifo_rdata;
        end
        default: par_en_d = 1'b0;
      endcase
    end else if (tick && state_q == ST_DATA) begin
      shreg_d = shreg_q >> 1;
    end

    // Line level for the coming cycle, so tx stays registered.
    unique case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shreg_d[0];
      ST_PARITY: tx_d = parbit_q;
      default:   tx_d = 1'b1;
    endcase
  end

  assign tx      = tx_q;
  assign tx_busy = (state_q != ST_IDLE);

endmodule
